cla_seq_adder: RTL

- Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-lookahead group for one nibble per clock, least-significant nibble first.
- The carry between nibbles is held in a register.
- Used in the EX stage as a low-area adder for multi-cycle ops (multiply/divide step helpers, address pre-compute).
- Start/busy/done handshake toward the pipeline control.

---
 rtl/cla_seq_pkg.sv | 21 ++
 rtl/cla_seq_adder_nib.sv | 36 +++
 rtl/cla_seq_adder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
// The state encoding and nib_sel() are used by cla_seq_adder.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W  = 4;
  localparam int SEL_IDX_W = 8;
  localparam int SEL_VEC_W = NIBBLE_W * (2 ** SEL_IDX_W);

  // Nibble k of a zero-extended vector.
  function automatic logic [NIBBLE_W-1:0] nib_sel(input logic [SEL_VEC_W-1:0] vec,
                                                  input logic [SEL_IDX_W-1:0] k);
    return vec[{k, 2'b00} +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/cla_seq_adder_nib.sv
// Combinational 4-bit carry-lookahead group: nibble sum, carries into bit 3
// and out of bit 3, and group generate/propagate.
module cla_nib_slice
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c0,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                c4,
  output logic                gg,
  output logic                pg
);

  logic [NIBBLE_W-1:0] g_s;
  logic [NIBBLE_W-1:0] p_s;
  logic                c1_s;
  logic                c2_s;

  // Lookahead equations for one nibble.
  always_comb begin
    g_s  = a & b;
    p_s  = a | b;
    c1_s = g_s[0] | (p_s[0] & c0);
    c2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c0);
    c3   = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
         | (p_s[2] & p_s[1] & p_s[0] & c0);
    gg   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
         | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    pg   = &p_s;
    c4   = gg | (pg & c0);
    s    = a ^ b ^ {c3, c2_s, c1_s, c0};
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one nibble per clock through a shared CLA group, LSB first.
// Optional macro CLA_SEQ_SUB_EN adds a 'sub' port (b inverted, carry forced to 1).
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 8) || (WIDTH > SEL_VEC_W)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t             state_r, state_nx_s;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r, b_r, sum_r;
  logic               busy_r, done_r, cout_r, ovf_r;
  logic               accept_s, last_s;
  logic [WIDTH-1:0]   b_cap_s;
  logic               cin_cap_s;
  logic [NIBBLE_W-1:0] a_nib_s, b_nib_s, nib_sum_s;
  logic               c3_s, c4_s, grp_g_s, grp_p_s;

  // Operand conditioning applied at capture time.
  always_comb begin
`ifdef CLA_SEQ_SUB_EN
    b_cap_s   = sub ? ~b : b;
    cin_cap_s = cin | sub;
`else
    b_cap_s   = b;
    cin_cap_s = cin;
`endif
  end

  // Nibble selection for the current step.
  always_comb begin
    a_nib_s = nib_sel(SEL_VEC_W'(a_r), SEL_IDX_W'(idx_r));
    b_nib_s = nib_sel(SEL_VEC_W'(b_r), SEL_IDX_W'(idx_r));
  end

  cla_nib_slice u_slice (
    .a  (a_nib_s),
    .b  (b_nib_s),
    .c0 (carry_r),
    .s  (nib_sum_s),
    .c3 (c3_s),
    .c4 (c4_s),
    .gg (grp_g_s),
    .pg (grp_p_s)
  );

  // Next-state logic; an accepted start in DONE restarts immediately.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (idx_r == LAST_IDX) begin
          last_s     = 1'b1;
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == S_RUN);
      done_r  <= (state_nx_s == S_DONE);
      if (accept_s) begin
        a_r     <= a;
        b_r     <= b_cap_s;
        carry_r <= cin_cap_s;
        idx_r   <= '0;
        sum_r   <= '0;
      end else if (state_r == S_RUN) begin
        sum_r[{idx_r, 2'b00} +: NIBBLE_W] <= nib_sum_s;
        carry_r <= c4_s;
        idx_r   <= idx_r + IDX_W'(1);
        if (last_s) begin
          // Group G/P gives the same carry-out as c4; c3 is the carry into the MSB.
          cout_r <= grp_g_s | (grp_p_s & carry_r);
          ovf_r  <= c3_s ^ c4_s;
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule
